// File: rtl/cr_clic_ctrl_nest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_ctrl_nest_pkg
// Description : Shared constants for the CLIC control/nesting block.
//               Provides the privilege-mode encodings, the cliccfg and
//               mintthresh field offsets, the clicinfo version field, the
//               threshold record type and small helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cr_clic_ctrl_nest_pkg;

  // Privilege-mode encodings (10 is reserved)
  localparam logic [1:0] c_MODE_U = 2'b00;
  localparam logic [1:0] c_MODE_S = 2'b01;
  localparam logic [1:0] c_MODE_M = 2'b11;

  // cliccfg field offsets
  localparam int c_CFG_NLBITS_LSB = 1;
  localparam int c_CFG_NLBITS_8   = 4;   // bit 4 set selects the full 8 level bits
  localparam int c_CFG_NMBITS_LSB = 5;
  localparam int c_CFG_CLR_FLAGS  = 31;  // write-1 clears the nesting ovf/unf flags

  // mintthresh field offsets
  localparam int c_MTH_LSB = 24;
  localparam int c_STH_LSB = 8;
  localparam int c_UTH_LSB = 0;

  // clicinfo version field
  localparam logic [6:0] c_INFO_VERSION = 7'd0;

  typedef struct packed {
    logic [7:0] mth;
    logic [7:0] sth;
    logic [7:0] uth;
  } thresh_t;

  // Only two mode bits are implemented; 3 saturates to 2.
  function automatic logic [1:0] clamp_nmbits(input logic [1:0] v);
    return (v == 2'b11) ? 2'b10 : v;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_clic_ctrl_nest_if.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_ctrl_nest_if
// Description : Register bus between the CLIC bus interface and the control
//               block. master = bus interface side, slave = control block.
// Signals     : busif_xx_write_vld        write strobe
//               busif_ctrl_cliccfg_sel    cliccfg selected
//               busif_ctrl_mintthresh_sel mintthresh selected
//               busif_kid_wdata           write data
//               ctrl_busif_*_val          register read values
// Revision    : 1.0 - initial release
// ============================================================================
interface cr_clic_ctrl_nest_if;
  logic        busif_xx_write_vld;
  logic        busif_ctrl_cliccfg_sel;
  logic        busif_ctrl_mintthresh_sel;
  logic [31:0] busif_kid_wdata;
  logic [31:0] ctrl_busif_cliccfg_val;
  logic [31:0] ctrl_busif_clicinfo_val;
  logic [31:0] ctrl_busif_mintthresh_val;

  modport master (
    output busif_xx_write_vld, busif_ctrl_cliccfg_sel, busif_ctrl_mintthresh_sel,
           busif_kid_wdata,
    input  ctrl_busif_cliccfg_val, ctrl_busif_clicinfo_val, ctrl_busif_mintthresh_val
  );

  modport slave (
    input  busif_xx_write_vld, busif_ctrl_cliccfg_sel, busif_ctrl_mintthresh_sel,
           busif_kid_wdata,
    output ctrl_busif_cliccfg_val, ctrl_busif_clicinfo_val, ctrl_busif_mintthresh_val
  );
endinterface
`default_nettype wire

// File: rtl/cr_clic_nest_stack.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_nest_stack
// Description : Saved-level stack for nested interrupt handlers. A take
//               pushes the running level and installs the new one, an exit
//               restores the previous level, take+exit together replaces the
//               running level in place.
// Ports       : clk, rst        clock, synchronous active-high reset
//               i_take, i_exit  handler entry / exit
//               i_new_level     level installed on take
//               i_clr_flags     clears the sticky ovf/unf flags
//               o_level         running handler level
//               o_depth         saved entries in use
//               o_ovf, o_unf    sticky overflow / underflow
// Revision    : 1.0 - initial release
// ============================================================================
module cr_clic_nest_stack #(
  parameter int NEST_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_take,
  input  wire logic       i_exit,
  input  wire logic       i_clr_flags,
  input  wire logic [7:0] i_new_level,
  output logic      [7:0] o_level,
  output logic      [4:0] o_depth,
  output logic            o_ovf,
  output logic            o_unf
);

  localparam logic [4:0] c_DEPTH_MAX = 5'(NEST_DEPTH);

  logic [7:0] r_stack [NEST_DEPTH];
  logic [7:0] r_level;
  logic [4:0] r_depth;
  logic       r_ovf;
  logic       r_unf;
  logic [7:0] w_top;

  // Most recently saved level (entry depth-1)
  always_comb begin
    w_top = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (r_depth == 5'(i + 1)) w_top = r_stack[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NEST_DEPTH; i++) r_stack[i] <= '0;
      r_level <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      // Clear first so that a fault in the same cycle still sets its flag
      if (i_clr_flags) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (i_take && i_exit) begin
        r_level <= i_new_level;
      end else if (i_take) begin
        r_level <= i_new_level;
        if (r_depth == c_DEPTH_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          for (int i = 0; i < NEST_DEPTH; i++) begin
            if (r_depth == 5'(i)) r_stack[i] <= r_level;
          end
          r_depth <= r_depth + 5'd1;
        end
      end else if (i_exit) begin
        if (r_depth != 5'd0) begin
          r_level <= w_top;
          r_depth <= r_depth - 5'd1;
        end else begin
          r_level <= '0;
          r_unf   <= 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_depth = r_depth;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule
`default_nettype wire

// File: rtl/cr_clic_ctrl_nest.sv
`default_nettype none
// ============================================================================
// Module      : cr_clic_ctrl_nest
// Description : CLIC control block with per-mode thresholds, nmbits mode
//               handling and a hardware nesting-level stack. Holds cliccfg,
//               clicinfo and mintthresh and filters the arbitrated interrupt
//               before registering it to the CPU.
// Ports       : clicreg_clk, cpurst       clock, synchronous active-high reset
//               busif                     register bus (slave modport)
//               cpu_clic_*                CPU mode, take/exit, exiting ID
//               arb_ctrl_int_*            arbiter winner
//               clic_cpu_int_*            registered interrupt to the CPU
//               ctrl_kid_ack_int          one-hot exit acknowledge
//               ctrl_xx_int_lv_or_mask    level/priority split mask
//               ctrl_nest_*               nesting level, depth, ovf, unf
// Revision    : 1.0 - initial release
// ============================================================================
module cr_clic_ctrl_nest
  import cr_clic_ctrl_nest_pkg::*;
#(
  parameter int CLICINTNUM     = 80,
  parameter int CLICINTCTLBITS = 3,
  parameter int ID_WIDTH       = 12,
  parameter int NEST_DEPTH     = 4
) (
  input  wire logic                      clicreg_clk,
  input  wire logic                      cpurst,
  cr_clic_ctrl_nest_if.slave             busif,
  input  wire logic [1:0]                cpu_clic_mode,
  input  wire logic                      cpu_clic_int_take,
  input  wire logic                      cpu_clic_int_exit,
  input  wire logic [ID_WIDTH-1:0]       cpu_clic_curid,
  input  wire logic                      arb_ctrl_int_hv,
  input  wire logic [ID_WIDTH-1:0]       arb_ctrl_int_id,
  input  wire logic [7:0]                arb_ctrl_int_il,
  input  wire logic [1:0]                arb_ctrl_int_mode,
  output logic                           clic_cpu_int_hv,
  output logic      [ID_WIDTH-1:0]       clic_cpu_int_id,
  output logic      [7:0]                clic_cpu_int_il,
  output logic      [1:0]                clic_cpu_int_priv,
  output logic      [CLICINTNUM-1:0]     ctrl_kid_ack_int,
  output logic      [CLICINTCTLBITS-1:0] ctrl_xx_int_lv_or_mask,
  output logic      [7:0]                ctrl_nest_level,
  output logic      [4:0]                ctrl_nest_depth,
  output logic                           ctrl_nest_ovf,
  output logic                           ctrl_nest_unf
);

  logic [3:0]          r_nlbits;
  logic [1:0]          r_nmbits;
  thresh_t             r_th;
  logic                r_hv;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_il;
  logic [1:0]          r_priv;

  logic        w_is_m;
  logic        w_cfg_wr;
  logic        w_mth_wr;
  logic [31:0] w_wdata;
  logic        w_unused_wdata;
  logic [1:0]  w_eff_mode;
  logic [7:0]  w_mode_th;
  logic [7:0]  w_eff_th;
  logic [7:0]  w_nest_level;

  assign w_wdata        = busif.busif_kid_wdata;
  assign w_unused_wdata = ^w_wdata[23:16];
  assign w_is_m         = (cpu_clic_mode == c_MODE_M);
  assign w_cfg_wr       = busif.busif_xx_write_vld && w_is_m && busif.busif_ctrl_cliccfg_sel;
  assign w_mth_wr       = busif.busif_xx_write_vld && w_is_m && busif.busif_ctrl_mintthresh_sel;

  // Configuration registers
  always_ff @(posedge clicreg_clk) begin
    if (cpurst) begin
      r_nlbits <= '0;
      r_nmbits <= '0;
      r_th     <= '0;
    end else begin
      if (w_cfg_wr) begin
        r_nlbits <= w_wdata[c_CFG_NLBITS_8] ? 4'd8 : w_wdata[c_CFG_NLBITS_LSB +: 4];
        r_nmbits <= clamp_nmbits(w_wdata[c_CFG_NMBITS_LSB +: 2]);
      end
      if (w_mth_wr) begin
        r_th.mth <= w_wdata[c_MTH_LSB +: 8];
        r_th.sth <= w_wdata[c_STH_LSB +: 8];
        r_th.uth <= w_wdata[c_UTH_LSB +: 8];
      end
    end
  end

  // Register reads are only visible to M-mode
  assign busif.ctrl_busif_cliccfg_val    = w_is_m ? {25'b0, r_nmbits, r_nlbits, 1'b1} : '0;
  assign busif.ctrl_busif_clicinfo_val   = w_is_m ? {c_INFO_VERSION, 4'(CLICINTCTLBITS), 8'b0,
                                                     13'(CLICINTNUM)} : '0;
  assign busif.ctrl_busif_mintthresh_val = w_is_m ? {r_th.mth, 8'b0, r_th.sth, r_th.uth} : '0;

  // Top nlbits bits of clicintctl are level, the rest priority
  for (genvar gi = 0; gi < CLICINTCTLBITS; gi++) begin : g_mask
    assign ctrl_xx_int_lv_or_mask[CLICINTCTLBITS-1-gi] = !(4'(gi) < r_nlbits);
  end

  // Arbiter modes outside the nmbits range map onto M
  always_comb begin
    w_eff_mode = arb_ctrl_int_mode;
    if (r_nmbits == 2'd0) begin
      w_eff_mode = c_MODE_M;
    end else if ((r_nmbits == 2'd1) && (arb_ctrl_int_mode == c_MODE_S)) begin
      w_eff_mode = c_MODE_M;
    end
    case (w_eff_mode)
      c_MODE_S: w_mode_th = r_th.sth;
      c_MODE_U: w_mode_th = r_th.uth;
      default:  w_mode_th = r_th.mth;
    endcase
  end

  // The running handler level only blocks interrupts of its own mode
  assign w_eff_th = (w_eff_mode == cpu_clic_mode) ? max8(w_mode_th, w_nest_level) : w_mode_th;

  always_ff @(posedge clicreg_clk) begin
    if (cpurst) begin
      r_hv   <= 1'b0;
      r_id   <= '0;
      r_il   <= '0;
      r_priv <= '0;
    end else begin
      r_hv   <= arb_ctrl_int_hv;
      r_id   <= arb_ctrl_int_id;
      r_il   <= (arb_ctrl_int_il > w_eff_th) ? arb_ctrl_int_il : 8'd0;
      r_priv <= w_eff_mode;
    end
  end

  assign clic_cpu_int_hv   = r_hv;
  assign clic_cpu_int_id   = r_id;
  assign clic_cpu_int_il   = r_il;
  assign clic_cpu_int_priv = r_priv;

  cr_clic_nest_stack #(
    .NEST_DEPTH (NEST_DEPTH)
  ) u_nest_stack (
    .clk         (clicreg_clk),
    .rst         (cpurst),
    .i_take      (cpu_clic_int_take),
    .i_exit      (cpu_clic_int_exit),
    .i_clr_flags (w_cfg_wr && w_wdata[c_CFG_CLR_FLAGS]),
    .i_new_level (r_il),
    .o_level     (w_nest_level),
    .o_depth     (ctrl_nest_depth),
    .o_ovf       (ctrl_nest_ovf),
    .o_unf       (ctrl_nest_unf)
  );

  assign ctrl_nest_level = w_nest_level;

  // Out-of-range IDs match no bit and acknowledge nothing
  for (genvar gi = 0; gi < CLICINTNUM; gi++) begin : g_ack
    assign ctrl_kid_ack_int[gi] = cpu_clic_int_exit && !cpurst && (32'(cpu_clic_curid) == gi);
  end

endmodule
`default_nettype wire
